// File: rtl/data_mem.sv
// Data memory for the M stage: 1024 x 32-bit words with byte-lane stores,
// write-first registered read, and alignment checking. Its outputs are
// registered for the W-stage load extender.
module data_mem (
   input  logic        clk,
   input  logic        reset,
   input  logic        En,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] Addr,
   input  logic [31:0] WD,
   input  logic [1:0]  BEOp,
   output logic [31:0] Dr,
   output logic [1:0]  AddrW,
   output logic [1:0]  BEOpW,
   output logic        AlignErr
);

   localparam int DEPTH = 1024;

   logic [31:0] mem_q [0:DEPTH-1];

   logic [31:0] dr_q,        dr_d;
   logic [1:0]  addr_w_q,    addr_w_d;
   logic [1:0]  beop_w_q,    beop_w_d;
   logic        align_err_q, align_err_d;

   logic [9:0]  idx;
   logic [3:0]  be;
   logic [31:0] lane;
   logic        misaligned;
   logic        commit;
   logic [31:0] old_word;
   logic [31:0] merged;

   // Lane enables for the access size (the fields below are all zero for 11).
   function automatic logic [3:0] byte_en(input logic [1:0] beop, input logic [1:0] a);
      logic [3:0] r;
      case (beop)
         2'b00:   r = 4'b1111;
         2'b01:   r = a[1] ? 4'b1100 : 4'b0011;
         2'b10:   r = 4'b0001 << a;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   // Store data replicated so any enabled lane sees the right bytes.
   function automatic logic [31:0] lane_data(input logic [1:0] beop, input logic [31:0] wd);
      logic [31:0] r;
      case (beop)
         2'b01:   r = {wd[15:0], wd[15:0]};
         2'b10:   r = {4{wd[7:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction

   // A misaligned or reserved-size access must not touch memory.
   function automatic logic is_misaligned(input logic [1:0] beop, input logic [1:0] a);
      logic r;
      case (beop)
         2'b00:   r = (a != 2'b00);
         2'b01:   r = a[0];
         2'b10:   r = 1'b0;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   // Decode the access, build the merged word, and form next-state values.
   always_comb begin
      idx        = Addr[11:2];
      be         = byte_en(BEOp, Addr[1:0]);
      lane       = lane_data(BEOp, WD);
      misaligned = is_misaligned(BEOp, Addr[1:0]);
      commit     = En & MemWrite & ~misaligned;
      old_word   = mem_q[idx];
      merged     = old_word;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) merged[8*b +: 8] = lane[8*b +: 8];
      end
      // Write-first: a committing store is visible in the same-edge read.
      dr_d        = commit ? merged : old_word;
      addr_w_d    = Addr[1:0];
      beop_w_d    = BEOp;
      align_err_d = (MemRead | MemWrite) & misaligned;
   end

   // Memory array: reset clears every word and overrides any store.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (commit) begin
         mem_q[idx] <= merged;
      end
   end

   // W-stage output registers: load on En, hold on stall, clear on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         dr_q        <= '0;
         addr_w_q    <= '0;
         beop_w_q    <= '0;
         align_err_q <= 1'b0;
      end else if (En) begin
         dr_q        <= dr_d;
         addr_w_q    <= addr_w_d;
         beop_w_q    <= beop_w_d;
         align_err_q <= align_err_d;
      end
   end

   assign Dr       = dr_q;
   assign AddrW    = addr_w_q;
   assign BEOpW    = beop_w_q;
   assign AlignErr = align_err_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem with hand-computed expected values.
module tb_data_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic        En;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] Addr;
   logic [31:0] WD;
   logic [1:0]  BEOp;
   logic [31:0] Dr;
   logic [1:0]  AddrW;
   logic [1:0]  BEOpW;
   logic        AlignErr;

   int n_checks = 0;
   int n_fail   = 0;

   data_mem dut (
      .clk      (clk),
      .reset    (reset),
      .En       (En),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .Addr     (Addr),
      .WD       (WD),
      .BEOp     (BEOp),
      .Dr       (Dr),
      .AddrW    (AddrW),
      .BEOpW    (BEOpW),
      .AlignErr (AlignErr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Apply one set of inputs across a rising edge; outputs are read 1 time unit later.
   task automatic step(input logic rst, input logic en, input logic mw, input logic mr,
                       input logic [31:0] a, input logic [31:0] wd, input logic [1:0] op);
      reset = rst; En = en; MemWrite = mw; MemRead = mr; Addr = a; WD = wd; BEOp = op;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, input logic [1:0] op);
      step(1'b0, 1'b1, 1'b0, 1'b1, a, 32'h0, op);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] op);
      step(1'b0, 1'b1, 1'b1, 1'b0, a, wd, op);
   endtask

   initial begin
      reset = 1'b1; En = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
      Addr = '0; WD = '0; BEOp = '0;
      #2;

      // Reset state and reads of cleared memory
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      check_eq("rst_dr", Dr, 32'h0);
      check_eq("rst_addrw", {30'h0, AddrW}, 32'h0);
      check_eq("rst_beopw", {30'h0, BEOpW}, 32'h0);
      check_eq("rst_alignerr", {31'h0, AlignErr}, 32'h0);
      rd(32'h0, 2'b00);     check_eq("rd_0x000", Dr, 32'h0);
      check_eq("rd_0x000_err", {31'h0, AlignErr}, 32'h0);
      rd(32'h7FC, 2'b00);   check_eq("rd_0x7fc", Dr, 32'h0);
      rd(32'hFFC, 2'b00);   check_eq("rd_0xffc", Dr, 32'h0);

      // Word store and load
      wr(32'h10, 32'h12345678, 2'b00);
      check_eq("wr_word_dr_wf", Dr, 32'h12345678);
      rd(32'h10, 2'b00);
      check_eq("rd_word", Dr, 32'h12345678);
      check_eq("rd_word_addrw", {30'h0, AddrW}, 32'h0);

      // Partial stores
      wr(32'h12, 32'h000000AB, 2'b10);
      rd(32'h10, 2'b00);    check_eq("after_byte", Dr, 32'h12AB5678);
      wr(32'h10, 32'h0000CDEF, 2'b01);
      rd(32'h10, 2'b00);    check_eq("after_half", Dr, 32'h12ABCDEF);
      rd(32'h13, 2'b10);
      check_eq("rd13_addrw", {30'h0, AddrW}, 32'h3);
      check_eq("rd13_beopw", {30'h0, BEOpW}, 32'h2);
      check_eq("rd13_dr", Dr, 32'h12ABCDEF);

      // Misalignment
      wr(32'h21, 32'hFFFFFFFF, 2'b00);
      check_eq("mis_word_st_err", {31'h0, AlignErr}, 32'h1);
      rd(32'h20, 2'b00);
      check_eq("mis_word_no_write", Dr, 32'h0);
      check_eq("aligned_rd_err", {31'h0, AlignErr}, 32'h0);
      rd(32'h23, 2'b01);
      check_eq("mis_half_ld_err", {31'h0, AlignErr}, 32'h1);
      rd(32'h10, 2'b11);
      check_eq("reserved_size_err", {31'h0, AlignErr}, 32'h1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h21, 32'h0, 2'b00);
      check_eq("mis_no_req_err", {31'h0, AlignErr}, 32'h0);
      wr(32'h11, 32'h00001111, 2'b01);   // misaligned halfword: no lane written
      check_eq("mis_half_st_err", {31'h0, AlignErr}, 32'h1);
      rd(32'h10, 2'b00);
      check_eq("mis_half_no_write", Dr, 32'h12ABCDEF);

      // Stall: outputs hold and no store commits
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h41, 32'h000000EE, 2'b10);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h41, 32'h000000EE, 2'b10);
      check_eq("stall_dr", Dr, 32'h12ABCDEF);
      check_eq("stall_addrw", {30'h0, AddrW}, 32'h0);
      check_eq("stall_beopw", {30'h0, BEOpW}, 32'h0);
      check_eq("stall_err", {31'h0, AlignErr}, 32'h0);
      rd(32'h40, 2'b00);
      check_eq("stall_no_write", Dr, 32'h0);

      // Read and write of the same word in one cycle
      wr(32'h50, 32'h11223344, 2'b00);
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h51, 32'h00000055, 2'b10);
      check_eq("rw_same_dr", Dr, 32'h11225544);
      check_eq("rw_same_err", {31'h0, AlignErr}, 32'h0);
      rd(32'h50, 2'b00);
      check_eq("rw_same_stored", Dr, 32'h11225544);

      // Address wrap modulo 4 KiB
      rd(32'h1010, 2'b00);
      check_eq("wrap_rd", Dr, 32'h12ABCDEF);
      wr(32'hFFFFF014, 32'hA5A5A5A5, 2'b00);
      rd(32'h14, 2'b00);
      check_eq("wrap_wr", Dr, 32'hA5A5A5A5);

      // Reset with En=0 still clears the outputs
      rd(32'h13, 2'b10);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0, 2'b10);
      check_eq("rst_en0_dr", Dr, 32'h0);
      check_eq("rst_en0_addrw", {30'h0, AddrW}, 32'h0);

      // Reset in the same cycle as a store drops the store
      rd(32'h50, 2'b00);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h99999999, 2'b00);
      check_eq("rst_st_dr", Dr, 32'h0);
      rd(32'h10, 2'b00);
      check_eq("rst_st_dropped", Dr, 32'h0);
      rd(32'h50, 2'b00);
      check_eq("rst_cleared_mem", Dr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The module SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 Port clk SHALL be an input of width 1: the system clock; all state updates occur on its rising edge.
REQ-003 Port reset SHALL be an input of width 1: the synchronous, active-high reset.
REQ-004 Port En SHALL be an input of width 1: the pipeline advance enable; 0 means hold (stall).
REQ-005 Port MemWrite SHALL be an input of width 1: the store request from stage M.
REQ-006 Port MemRead SHALL be an input of width 1: the load request from stage M.
REQ-007 Port Addr SHALL be an input of width 32: the byte address from the ALU.
REQ-008 Port WD SHALL be an input of width 32: the store data, with the value right-aligned in the low bits.
REQ-009 Port BEOp SHALL be an input of width 2: the access size, 00 = word, 01 = halfword, 10 = byte, 11 = reserved.
REQ-010 Port Dr SHALL be an output of width 32: the registered raw word read; it feeds the W-stage load extender.
REQ-011 Port AddrW SHALL be an output of width 2: the registered Addr[1:0], passed to the W stage with Dr.
REQ-012 Port BEOpW SHALL be an output of width 2: the registered BEOp, passed to the W stage.
REQ-013 Port AlignErr SHALL be an output of width 1: the registered flag marking a misaligned or reserved-size access.

Function
REQ-014 Storage SHALL be 1024 x 32-bit words, indexed by Addr[11:2]; Addr[31:12] SHALL be ignored, so addresses wrap modulo 4 KiB.
REQ-015 Byte enables SHALL follow the access size.
- Word: 4'b1111.
- Halfword: 4'b0011 when Addr[1]=0, 4'b1100 when Addr[1]=1.
- Byte: 4'b0001 shifted left by Addr[1:0].
REQ-016 Store lane data SHALL be as follows.
- Word: WD unchanged.
- Halfword: {WD[15:0], WD[15:0]}.
- Byte: WD[7:0] replicated into all four lanes.
Only the enabled lanes SHALL be written.
REQ-017 An access SHALL be misaligned in any of these cases: word with Addr[1:0]!=00; halfword with Addr[0]=1; BEOp=11.
REQ-018 A store SHALL commit at the rising edge when En=1, MemWrite=1, reset=0 and the access is not misaligned; otherwise the memory SHALL be unchanged.
REQ-019 Read latency SHALL be 1 cycle: at the edge where En=1, Dr SHALL load mem[Addr[11:2]] and AddrW SHALL load Addr[1:0]. Dr also loads when MemRead=0, so it is don't-care for non-loads but is still deterministic.
REQ-020 Read-during-write to the same word SHALL be write-first: Dr SHALL return the merged post-store word.
REQ-021 BEOpW SHALL load BEOp at each edge where En=1.
REQ-022 AlignErr SHALL load (MemRead|MemWrite) & misaligned at each edge where En=1.
REQ-023 When En=0, Dr, AddrW, BEOpW and AlignErr SHALL hold their values and no store SHALL commit.
REQ-024 When MemRead=1 and MemWrite=1 together, the block SHALL perform the store and the write-first read, and SHALL raise no error unless the access is misaligned.
REQ-025 A misaligned store SHALL write no byte at all, including lanes that would otherwise be valid.

Reset
REQ-026 When reset=1 at a rising edge, Dr, AddrW, BEOpW and AlignErr SHALL become 0, whatever the value of En.
REQ-027 When reset=1, all 1024 memory words SHALL become 0, overriding any store in the same cycle.
REQ-028 A reset asserted mid-sequence SHALL discard any pending output, and the first access after reset SHALL see all-zero memory.

Verification
REQ-029 Reset behaviour: reset for 1 cycle, then read Addr=0x0, 0x7FC and 0xFFC -> Dr=0 each cycle; AlignErr=0.
REQ-030 Word store/load: write Addr=0x10, WD=0x12345678, BEOp=00, then read 0x10 -> Dr=0x12345678 one cycle after the read edge; AddrW=00.
REQ-031 Partial stores:
- Starting word: 0x12345678 at 0x10.
- Store byte 0xAB (BEOp=10) to 0x12.
- Store halfword 0xCDEF (BEOp=01) to 0x10.
- Read 0x10 -> Dr=0x12ABCDEF.
- Read 0x13 -> AddrW=11.
REQ-032 Misalignment: word store to 0x21 with WD=0xFFFFFFFF -> AlignErr=1 next cycle, and mem[0x20] stays 0. A halfword load at 0x23 -> AlignErr=1. BEOp=11 with MemRead=1 -> AlignErr=1.
REQ-033 Stall and write-first:
- En=0 for 2 cycles with MemWrite=1 -> no write occurs and all outputs hold.
- Read and write of the same word in one cycle -> Dr shows the merged new word.
REQ-034 Wrap and reset: Addr=0x1010 aliases to 0x010 -> Dr=0x12ABCDEF. Reset asserted in the same cycle as a store -> the store is dropped, and a read afterwards gives Dr=0.
